// File: rtl/sum_loop_pkg.sv
// rtl/sum_loop_pkg.sv - shared types for the sum loop engine
package sum_loop_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    CHECK = 3'd2,
    ADD   = 3'd3,
    INC   = 3'd4,
    OUT   = 3'd5,
    DONE  = 3'd6
  } sum_loop_state_e;

endpackage

// File: rtl/sum_loop_datapath.sv
// rtl/sum_loop_datapath.sv - accumulator, loop index, latched bounds and compare
module sum_loop_datapath
  import sum_loop_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CNT_W-1:0]  limit,
  input  logic [CNT_W-1:0]  step,
  input  logic              load_en,
  input  logic              init_en,
  input  logic              add_en,
  input  logic              inc_en,
  output logic              idx_le_lim,
  output logic [DATA_W-1:0] sum,
  output logic              overflow
);

  // One extra index bit keeps idx+step from wrapping, so CHECK always terminates.
  localparam int IW = CNT_W + 1;
  localparam int AW = ((DATA_W > IW) ? DATA_W : IW) + 1;

  logic [DATA_W-1:0] sum_q;
  logic [IW-1:0]     idx_q;
  logic [CNT_W-1:0]  lim_q;
  logic [CNT_W-1:0]  step_q;
  logic              ovf_q;

  logic [AW-1:0]     add_full;
  logic              carry;
  logic [CNT_W-1:0]  step_d;

  assign add_full = AW'(sum_q) + AW'(idx_q);
  assign carry    = |add_full[AW-1:DATA_W];
  assign step_d   = (step == '0) ? CNT_W'(1) : step;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_q  <= '0;
      idx_q  <= '0;
      lim_q  <= '0;
      step_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (load_en) begin
        lim_q  <= limit;
        step_q <= step_d;
      end
      if (init_en) begin
        sum_q <= '0;
        idx_q <= IW'(1);
        ovf_q <= 1'b0;
      end
      if (add_en) begin
        sum_q <= add_full[DATA_W-1:0];
        if (carry) ovf_q <= 1'b1;
      end
      if (inc_en) idx_q <= idx_q + IW'(step_q);
    end
  end

  assign idx_le_lim = (idx_q <= IW'(lim_q));
  assign sum        = sum_q;
  assign overflow   = ovf_q;

endmodule

// File: rtl/sum_loop_engine.sv
// rtl/sum_loop_engine.sv - sequenced 1..limit stepped summation engine
module sum_loop_engine
  import sum_loop_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  limit,
  input  logic [CNT_W-1:0]  step,
  output logic              busy,
  output logic              done,
  output logic              out_valid,
  output logic [DATA_W-1:0] sum,
  output logic              overflow
);

  sum_loop_state_e state_q, state_d;
  logic load_en, init_en, add_en, inc_en, idx_le_lim;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load_en = 1'b0;
    init_en = 1'b0;
    add_en  = 1'b0;
    inc_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load_en = 1'b1;
          state_d = INIT;
        end
      end
      INIT: begin
        init_en = 1'b1;
        state_d = CHECK;
      end
      CHECK:   state_d = idx_le_lim ? ADD : DONE;
      ADD: begin
        add_en  = 1'b1;
        state_d = INC;
      end
      INC: begin
        inc_en  = 1'b1;
        state_d = OUT;
      end
      OUT:     state_d = CHECK;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign out_valid = (state_q == OUT);

  sum_loop_datapath #(
    .DATA_W(DATA_W),
    .CNT_W (CNT_W)
  ) u_datapath (
    .clk       (clk),
    .reset     (reset),
    .limit     (limit),
    .step      (step),
    .load_en   (load_en),
    .init_en   (init_en),
    .add_en    (add_en),
    .inc_en    (inc_en),
    .idx_le_lim(idx_le_lim),
    .sum       (sum),
    .overflow  (overflow)
  );

endmodule

// File: tb/tb_sum_loop_engine.sv
// tb/tb_sum_loop_engine.sv - randomized bench against a behavioural summation model
module tb_sum_loop_engine;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start16 = 1'b0;
  logic        start8 = 1'b0;
  logic [7:0]  limit = '0;
  logic [7:0]  step = '0;

  logic        busy16, done16, ov16, ovf16;
  logic [15:0] sum16;
  logic        busy8, done8, ov8, ovf8;
  logic [7:0]  sum8;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sum_loop_engine #(.DATA_W(16), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .start(start16), .limit(limit), .step(step),
    .busy(busy16), .done(done16), .out_valid(ov16), .sum(sum16), .overflow(ovf16)
  );

  sum_loop_engine #(.DATA_W(8), .CNT_W(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .limit(limit), .step(step),
    .busy(busy8), .done(done8), .out_valid(ov8), .sum(sum8), .overflow(ovf8)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Observed outputs of the selected instance, widened to a common size.
  task automatic sample(input bit w8, output bit b, output bit d, output bit v,
                        output longint s, output bit o);
    if (w8) begin b = busy8;  d = done8;  v = ov8;  s = longint'(sum8);  o = ovf8;  end
    else    begin b = busy16; d = done16; v = ov16; s = longint'(sum16); o = ovf16; end
  endtask

  task automatic run(input bit w8, input int lim, input int st, input bit disturb);
    longint exp_q[$];
    longint acc, modv, s;
    bit     exp_ovf, b, d, v, o;
    int     eff, n, got, done_at, bound;
    modv = w8 ? 256 : 65536;
    eff  = (st == 0) ? 1 : st;
    acc = 0; exp_ovf = 0;
    for (int i = 1; i <= lim; i += eff) begin
      acc += i;
      if (acc >= modv) begin acc -= modv; exp_ovf = 1; end
      exp_q.push_back(acc);
    end
    @(negedge clk);
    limit = 8'(lim); step = 8'(st);
    if (w8) start8 = 1'b1; else start16 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0; start16 = 1'b0;
    n = 1; got = 0; done_at = -1; bound = 4 * 256 + 16;
    while (n <= bound) begin
      sample(w8, b, d, v, s, o);
      if (n == 1) check("busy_in_run", longint'(b), 1);
      if (v) begin
        if (got < exp_q.size()) check("iter_sum", s, exp_q[got]);
        else check("extra_out_valid", longint'(got), longint'(exp_q.size()));
        got++;
      end
      if (d) begin
        done_at = n;
        break;
      end
      if (disturb) begin
        limit = 8'($urandom);
        step  = 8'($urandom);
        if (w8) start8 = 1'($urandom); else start16 = 1'($urandom);
      end
      @(negedge clk);
      n++;
    end
    start8 = 1'b0; start16 = 1'b0;
    check("done_cycle", longint'(done_at), longint'(3 + 4 * exp_q.size()));
    check("iter_count", longint'(got), longint'(exp_q.size()));
    check("final_sum", s, acc);
    check("final_ovf", longint'(o), longint'(exp_ovf));
    @(negedge clk);
    @(negedge clk);
    sample(w8, b, d, v, s, o);
    check("idle_busy", longint'(b), 0);
    check("hold_sum", s, acc);
    check("hold_ovf", longint'(o), longint'(exp_ovf));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_sum", longint'(sum16), 0);
    check("rst_busy", longint'(busy16), 0);
    check("rst_done", longint'(done16), 0);
    check("rst_valid", longint'(ov16), 0);
    check("rst_ovf", longint'(ovf16), 0);
    reset = 1'b0;

    run(0, 10, 1, 0);
    run(0, 0, 1, 0);
    run(0, 10, 3, 0);
    run(0, 4, 0, 0);
    run(1, 30, 1, 0);
    run(1, 3, 1, 0);
    run(0, 255, 255, 0);
    run(0, 255, 1, 0);
    run(0, 7, 2, 1);

    // Asynchronous reset mid-run must clear everything without waiting for a clock.
    @(negedge clk);
    limit = 8'd20; step = 8'd1; start16 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start16 = 1'b0;
    repeat (9) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_sum", longint'(sum16), 0);
    check("mid_rst_busy", longint'(busy16), 0);
    check("mid_rst_done", longint'(done16), 0);
    check("mid_rst_valid", longint'(ov16), 0);
    check("mid_rst_ovf", longint'(ovf16), 0);
    @(negedge clk);
    reset = 1'b0;
    run(0, 5, 2, 0);

    for (int k = 0; k < 20; k++)
      run(1'($urandom), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 1'($urandom));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
